trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
//  Initiator side of the CSR context-switch interface. Collects synchronous exceptions from the
//  pipeline and pending interrupts, prioritises them, and drains or flushes the pipeline.
//  Drives CS/CAUSE/NPC into the CSR file for one cycle, then waits a fixed CSR latency.
//  Finally issues a one-cycle fetch redirect to the trap vector the CSR file returns on PC_OUT.
// PARAMETERS
//  IRQ_W    3       number of interrupt lines; bit0=software(code 3), bit1=timer(7), bit2=external(11)
//  CSR_LAT  1       cycles from CS high to PC_OUT valid from the CSR file (>=1)
//  RESET_PC 64'h0   reset value of the last-retired next-PC register
// PORTS
//  CLK          in   1      clock
//  RESET        in   1      synchronous, active-high reset
//  EXC_VALID    in   1      pipeline reports a synchronous exception this cycle
//  EXC_CODE     in   6      exception code (RISC-V mcause encoding, interrupt bit clear)
//  EXC_PC       in   64     PC of the faulting instruction
//  IRQ_PEND     in   IRQ_W  level-sensitive pending interrupt lines
//  IRQ_EN       in   IRQ_W  per-line enable (mie)
//  GLOBAL_IE    in   1      global interrupt enable (status.xie of the current privilege)
//  RET_BUSY     in   1      xRET in decode/execute; blocks new interrupt acceptance
//  RETIRE_VALID in   1      an instruction retires this cycle
//  RETIRE_NPC   in   64     architectural next PC of the retiring instruction
//  PIPE_EMPTY   in   1      no instructions in flight
//  PC_IN        in   64     trap vector from the CSR file (its PC_OUT)
//  CS           out  1      context-switch strobe to the CSR file
//  CAUSE        out  64     cause value; bit63=interrupt, [5:0]=code, others 0
//  NPC          out  64     PC saved into xEPC
//  STALL        out  1      hold fetch (no new instructions enter)
//  FLUSH        out  1      kill all in-flight instructions
//  REDIRECT     out  1      one-cycle fetch redirect strobe
//  REDIRECT_PC  out  64     redirect target (= PC_IN sampled)
//  BUSY         out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; LAST_NPC<=RESET_PC; wait counter 0. A RESET arriving in any state
//   aborts the trap in progress and drops CS/REDIRECT the next edge.
//  LAST_NPC: loads RETIRE_NPC on every RETIRE_VALID cycle, in every state.
//  Interrupt take condition: IRQ_TAKE = GLOBAL_IE & ~RET_BUSY & |(IRQ_PEND & IRQ_EN).
//  Interrupt priority: external > software > timer. Exception always beats an interrupt in the same cycle.
//  States:
//   IDLE: EXC_VALID -> latch CAUSE={58'b0,EXC_CODE}, NPC=EXC_PC; FLUSH=1 (combinational, this cycle) -> SIGNAL.
//     else IRQ_TAKE -> STALL=1, latch winning line's code with bit63=1 -> DRAIN.
//   DRAIN: STALL=1. EXC_VALID -> discard interrupt, latch exception as in IDLE, FLUSH=1 -> SIGNAL
//     (the interrupt stays pending and is re-evaluated later). Else PIPE_EMPTY -> NPC=LAST_NPC
//     (including a retire in this same cycle: use RETIRE_NPC) -> SIGNAL. The interrupt is NOT
//     re-checked during drain; a line deasserting mid-drain still completes the trap.
//   SIGNAL: CS=1 for exactly one cycle with stable CAUSE/NPC; STALL=1; load counter=CSR_LAT-1 -> WAIT.
//   WAIT: STALL=1; decrement the counter; at 0 sample PC_IN into REDIRECT_PC -> REDIRECT.
//   REDIRECT: REDIRECT=1 for one cycle, STALL=0 -> IDLE.
//  In SIGNAL/WAIT/REDIRECT, EXC_VALID and IRQ inputs are ignored because the pipeline is flushed or stalled.
//  CAUSE/NPC hold their last values after CS; consumers sample only while CS=1.
//  Back-to-back: an event in the cycle after REDIRECT (in IDLE) is accepted normally. Minimum trap-to-trap
//   spacing is 3+CSR_LAT cycles.
//  BUSY = (state != IDLE). FLUSH asserts only in the cycle an exception is accepted.
// STRUCTURE
//  Shared package (csr_pkg): exception/interrupt cause codes, CAUSE_INT_BIT=63, FSM state encoding,
//   and interrupt line indices.
//  One sub-module, irq_prio_enc: IRQ_W-bit pending&enable -> {hit, 6-bit code}, purely combinational.
//  Remaining logic: FSM, LAST_NPC register, CSR_LAT counter, output registers.
// TESTING
//  1 EXC_VALID, code 2, EXC_PC=0x1000 -> FLUSH same cycle; CS=1 next cycle with CAUSE=0x2, NPC=0x1000;
//    PC_IN=0x208 -> REDIRECT=1 with PC 0x208 at CS+CSR_LAT+1.
//  2 GLOBAL_IE=1, IRQ_EN=3'b111, IRQ_PEND=3'b110, last retire NPC=0x2004, PIPE_EMPTY after 3 cycles
//    -> STALL for the whole window; CS with CAUSE=0x8000_0000_0000_000B, NPC=0x2004.
//  3 Timer pending and exception code 5 in the same cycle -> CAUSE=0x5 only; after the first trap
//    completes, with GLOBAL_IE still 1, a second CS with CAUSE bit63=1, code 7.
//  4 Interrupt in DRAIN, then EXC_VALID code 13 at 0x3000 before PIPE_EMPTY -> single CS, CAUSE=0xD, NPC=0x3000.
//  5 GLOBAL_IE=0 or RET_BUSY=1 with IRQ_PEND all ones -> no STALL, no CS for 20 cycles.
//  6 RESET asserted during WAIT (CSR_LAT=4) -> next cycle: CS=STALL=REDIRECT=BUSY=0, no redirect issued.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: cause codes, interrupt line indices and trap FSM encoding shared by the trap controller
package csr_pkg;
    localparam int CAUSE_INT_BIT = 63;
    localparam int IRQ_SW  = 0;
    localparam int IRQ_TIM = 1;
    localparam int IRQ_EXT = 2;
    localparam logic [5:0] CODE_SW_IRQ  = 6'd3;
    localparam logic [5:0] CODE_TIM_IRQ = 6'd7;
    localparam logic [5:0] CODE_EXT_IRQ = 6'd11;
    typedef enum logic [2:0] {ST_IDLE, ST_DRAIN, ST_SIGNAL, ST_WAIT, ST_REDIRECT} state_t;
    function automatic logic [63:0] irq_cause(input logic [5:0] code);
        irq_cause = 64'(code);
        irq_cause[CAUSE_INT_BIT] = 1'b1;
    endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: picks the winning interrupt line (external > software > timer) and its cause code
module irq_prio_enc
    import csr_pkg::*;
#(
    parameter int IRQ_W = 3
) (
    input  logic [IRQ_W-1:0] pend_en,
    output logic             hit,
    output logic [5:0]       code
);
    // fixed priority select over the three architectural lines
    always_comb begin
        hit  = pend_en[IRQ_EXT] | pend_en[IRQ_SW] | pend_en[IRQ_TIM];
        code = pend_en[IRQ_EXT] ? CODE_EXT_IRQ :
               pend_en[IRQ_SW]  ? CODE_SW_IRQ  :
               pend_en[IRQ_TIM] ? CODE_TIM_IRQ : 6'd0;
    end
endmodule

// File: rtl/trap_controller.sv
// trap_controller: accepts exceptions/interrupts, drains or flushes, signals the CSR file, redirects fetch
module trap_controller
    import csr_pkg::*;
#(
    parameter int          IRQ_W    = 3,
    parameter int          CSR_LAT  = 1,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EXC_VALID,
    input  logic [5:0]       EXC_CODE,
    input  logic [63:0]      EXC_PC,
    input  logic [IRQ_W-1:0] IRQ_PEND,
    input  logic [IRQ_W-1:0] IRQ_EN,
    input  logic             GLOBAL_IE,
    input  logic             RET_BUSY,
    input  logic             RETIRE_VALID,
    input  logic [63:0]      RETIRE_NPC,
    input  logic             PIPE_EMPTY,
    input  logic [63:0]      PC_IN,
    output logic             CS,
    output logic [63:0]      CAUSE,
    output logic [63:0]      NPC,
    output logic             STALL,
    output logic             FLUSH,
    output logic             REDIRECT,
    output logic [63:0]      REDIRECT_PC,
    output logic             BUSY
);
    localparam int CW = CSR_LAT > 1 ? $clog2(CSR_LAT) : 1;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [63:0]   last_npc, cause_d, npc_d, rpc_d;
    logic          irq_hit, irq_take;
    logic [5:0]    irq_code;

    irq_prio_enc #(.IRQ_W(IRQ_W)) u_prio (
        .pend_en (IRQ_PEND & IRQ_EN),
        .hit     (irq_hit),
        .code    (irq_code)
    );

    assign irq_take = GLOBAL_IE & ~RET_BUSY & irq_hit;
    assign CS       = state == ST_SIGNAL;
    assign REDIRECT = state == ST_REDIRECT;
    assign BUSY     = state != ST_IDLE;

    // state, wait counter, latched CSR payload and last retired next-PC
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            CAUSE       <= '0;
            NPC         <= '0;
            REDIRECT_PC <= '0;
            last_npc    <= RESET_PC;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            CAUSE       <= cause_d;
            NPC         <= npc_d;
            REDIRECT_PC <= rpc_d;
            if (RETIRE_VALID) last_npc <= RETIRE_NPC;
        end
    end

    // next state, payload capture and the combinational STALL/FLUSH strobes
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cause_d = CAUSE;
        npc_d   = NPC;
        rpc_d   = REDIRECT_PC;
        STALL   = 1'b0;
        FLUSH   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (EXC_VALID) begin
                    cause_d = 64'(EXC_CODE);
                    npc_d   = EXC_PC;
                    FLUSH   = 1'b1;
                    state_d = ST_SIGNAL;
                end else if (irq_take) begin
                    cause_d = irq_cause(irq_code);
                    STALL   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                STALL = 1'b1;
                if (EXC_VALID) begin
                    cause_d = 64'(EXC_CODE);
                    npc_d   = EXC_PC;
                    FLUSH   = 1'b1;
                    state_d = ST_SIGNAL;
                end else if (PIPE_EMPTY) begin
                    npc_d   = RETIRE_VALID ? RETIRE_NPC : last_npc;
                    state_d = ST_SIGNAL;
                end
            end
            ST_SIGNAL: begin
                STALL   = 1'b1;
                cnt_d   = CW'(CSR_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                STALL   = 1'b1;
                cnt_d   = cnt == '0 ? cnt : cnt - 1'b1;
                rpc_d   = cnt == '0 ? PC_IN : REDIRECT_PC;
                state_d = cnt == '0 ? ST_REDIRECT : ST_WAIT;
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (RESET) begin
            STALL = 1'b0;
            FLUSH = 1'b0;
        end
    end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed and randomized traps checked against a transaction-level reference model
module tb_trap_controller;
    localparam int          LAT = 4;
    localparam logic [63:0] RPC = 64'h0000_0000_DEAD_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        EXC_VALID, GLOBAL_IE, RET_BUSY, RETIRE_VALID, PIPE_EMPTY;
    logic [5:0]  EXC_CODE;
    logic [63:0] EXC_PC, RETIRE_NPC, PC_IN;
    logic [2:0]  IRQ_PEND, IRQ_EN;
    logic        CS, STALL, FLUSH, REDIRECT, BUSY;
    logic [63:0] CAUSE, NPC, REDIRECT_PC;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] last_npc;
    bit          ret_en = 1'b1;

    trap_controller #(.IRQ_W(3), .CSR_LAT(LAT), .RESET_PC(RPC)) dut (
        .CLK(CLK), .RESET(RESET), .EXC_VALID(EXC_VALID), .EXC_CODE(EXC_CODE), .EXC_PC(EXC_PC),
        .IRQ_PEND(IRQ_PEND), .IRQ_EN(IRQ_EN), .GLOBAL_IE(GLOBAL_IE), .RET_BUSY(RET_BUSY),
        .RETIRE_VALID(RETIRE_VALID), .RETIRE_NPC(RETIRE_NPC), .PIPE_EMPTY(PIPE_EMPTY), .PC_IN(PC_IN),
        .CS(CS), .CAUSE(CAUSE), .NPC(NPC), .STALL(STALL), .FLUSH(FLUSH), .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference: interrupt cause from the priority table external, software, timer
    function automatic logic [63:0] irq_ref(input logic [2:0] m);
        int lines [3] = '{2, 0, 1};
        int codes [3] = '{11, 3, 7};
        for (int k = 0; k < 3; k++)
            if (m[lines[k]]) return (64'd1 << 63) + 64'(codes[k]);
        return 64'd0;
    endfunction

    task automatic quiet();
        EXC_VALID = 0; EXC_CODE = 0; EXC_PC = 0; IRQ_PEND = 0; IRQ_EN = 0; GLOBAL_IE = 0;
        RET_BUSY = 0; RETIRE_VALID = 0; RETIRE_NPC = 0; PIPE_EMPTY = 1; PC_IN = 0;
    endtask

    task automatic retire_rand();
        RETIRE_VALID = ret_en ? 1'($urandom_range(0, 1)) : 1'b0;
        RETIRE_NPC   = {$urandom, $urandom};
    endtask

    task automatic commit();
        if (RETIRE_VALID) last_npc = RETIRE_NPC;
    endtask

    task automatic garbage();
        EXC_VALID = 1'($urandom_range(0, 1)); EXC_CODE = 6'($urandom); EXC_PC = {$urandom, $urandom};
        IRQ_PEND = 3'($urandom); IRQ_EN = 3'($urandom); GLOBAL_IE = 1'($urandom_range(0, 1));
        RET_BUSY = 0; PIPE_EMPTY = 1'($urandom_range(0, 1)); PC_IN = {$urandom, $urandom};
        retire_rand();
    endtask

    // CS cycle, CSR_LAT wait cycles, redirect cycle; trap inputs are noise throughout
    task automatic tail(input logic [63:0] ec, input logic [63:0] en, input logic [63:0] pcin);
        @(negedge CLK); garbage(); #1;
        chk("cs", CS, 1); chk("cause", CAUSE, ec); chk("npc", NPC, en);
        chk("stall_sig", STALL, 1); chk("flush_sig", FLUSH, 0); commit();
        for (int i = 0; i < LAT; i++) begin
            @(negedge CLK); garbage(); if (i == LAT - 1) PC_IN = pcin; #1;
            chk("cs_wait", CS, 0); chk("stall_wait", STALL, 1);
            chk("redir_wait", REDIRECT, 0); chk("busy_wait", BUSY, 1); commit();
        end
        @(negedge CLK); garbage(); #1;
        chk("redirect", REDIRECT, 1); chk("redirect_pc", REDIRECT_PC, pcin);
        chk("stall_redir", STALL, 0); chk("cs_redir", CS, 0); commit();
    endtask

    task automatic run_exc(input logic [5:0] code, input logic [63:0] pc, input logic [2:0] bg, input logic ie,
                           input logic [63:0] pcin);
        @(negedge CLK); quiet(); EXC_VALID = 1; EXC_CODE = code; EXC_PC = pc;
        IRQ_PEND = bg; IRQ_EN = 3'b111; GLOBAL_IE = ie; PIPE_EMPTY = 0; retire_rand(); #1;
        chk("flush_exc", FLUSH, 1); chk("stall_exc", STALL, 0); chk("busy_exc", BUSY, 0); chk("cs_exc", CS, 0);
        commit();
        tail(64'(code), pc, pcin);
    endtask

    task automatic irq_start(input logic [2:0] pend, input logic [2:0] en);
        @(negedge CLK); quiet(); IRQ_PEND = pend; IRQ_EN = en; GLOBAL_IE = 1; PIPE_EMPTY = 0; retire_rand(); #1;
        chk("stall_irq", STALL, 1); chk("flush_irq", FLUSH, 0); chk("busy_irq", BUSY, 0); commit();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK); quiet(); IRQ_PEND = 3'($urandom); IRQ_EN = 3'($urandom); GLOBAL_IE = 1;
            PIPE_EMPTY = 0; retire_rand(); #1;
            chk("stall_drain", STALL, 1); chk("cs_drain", CS, 0); chk("busy_drain", BUSY, 1);
            chk("flush_drain", FLUSH, 0); commit();
        end
    endtask

    task automatic run_irq(input logic [2:0] pend, input logic [2:0] en, input int n, input logic [63:0] pcin);
        logic [63:0] en_npc;
        irq_start(pend, en);
        drain(n);
        @(negedge CLK); quiet(); PIPE_EMPTY = 1; retire_rand(); #1;
        en_npc = RETIRE_VALID ? RETIRE_NPC : last_npc;
        chk("stall_empty", STALL, 1); chk("cs_empty", CS, 0); commit();
        tail(irq_ref(pend & en), en_npc, pcin);
    endtask

    task automatic run_irq_exc(input logic [2:0] pend, input logic [2:0] en, input int n,
                               input logic [5:0] code, input logic [63:0] pc, input logic [63:0] pcin);
        irq_start(pend, en);
        drain(n);
        @(negedge CLK); quiet(); EXC_VALID = 1; EXC_CODE = code; EXC_PC = pc; IRQ_PEND = pend; IRQ_EN = en;
        GLOBAL_IE = 1; PIPE_EMPTY = 1'($urandom_range(0, 1)); retire_rand(); #1;
        chk("flush_drain_exc", FLUSH, 1); chk("stall_drain_exc", STALL, 1); commit();
        tail(64'(code), pc, pcin);
    endtask

    initial begin
        logic [2:0] p, e;
        quiet();
        last_npc = RPC;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_cs", CS, 0); chk("rst_busy", BUSY, 0); chk("rst_redir", REDIRECT, 0);
        chk("rst_cause", CAUSE, 0); chk("rst_npc", NPC, 0); chk("rst_rpc", REDIRECT_PC, 0);
        chk("rst_stall", STALL, 0); chk("rst_flush", FLUSH, 0);
        RESET = 0;
        ret_en = 0;
        run_irq(3'b001, 3'b111, 0, 64'h44);
        ret_en = 1;
        run_exc(6'd2, 64'h1000, 3'b000, 1'b0, 64'h208);
        @(negedge CLK); quiet(); RETIRE_VALID = 1; RETIRE_NPC = 64'h2004; #1;
        chk("idle_after_redir", BUSY, 0); commit();
        ret_en = 0;
        run_irq(3'b110, 3'b111, 3, 64'h300);
        ret_en = 1;
        run_exc(6'd5, 64'h1234, 3'b010, 1'b1, 64'h400);
        run_irq(3'b010, 3'b111, 1, 64'h500);
        run_irq_exc(3'b100, 3'b111, 2, 6'd13, 64'h3000, 64'h600);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK); quiet(); IRQ_PEND = 3'b111; IRQ_EN = 3'b111;
            GLOBAL_IE = i >= 20; RET_BUSY = i >= 20; #1;
            chk("blocked_stall", STALL, 0); chk("blocked_cs", CS, 0);
        end
        @(negedge CLK); quiet(); EXC_VALID = 1; EXC_CODE = 6'd1; EXC_PC = 64'h44; #1;
        chk("flush_pre_rst", FLUSH, 1);
        @(negedge CLK); quiet(); #1; chk("cs_pre_rst", CS, 1);
        @(negedge CLK); quiet(); #1; chk("busy_pre_rst", BUSY, 1);
        @(negedge CLK); quiet(); RESET = 1;
        @(negedge CLK); RESET = 0; quiet(); #1;
        last_npc = RPC;
        chk("abort_cs", CS, 0); chk("abort_stall", STALL, 0); chk("abort_redir", REDIRECT, 0);
        chk("abort_busy", BUSY, 0); chk("abort_cause", CAUSE, 0); chk("abort_rpc", REDIRECT_PC, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK); quiet(); PC_IN = {$urandom, $urandom}; #1;
            chk("no_redir", REDIRECT, 0); chk("no_busy", BUSY, 0);
        end
        ret_en = 0;
        run_irq(3'b011, 3'b111, 0, 64'h700);
        ret_en = 1;
        for (int it = 0; it < 40; it++) begin
            p = 3'($urandom_range(1, 7));
            do e = 3'($urandom_range(1, 7)); while ((p & e) == 0);
            case ($urandom_range(0, 2))
                0: run_exc(6'($urandom_range(0, 15)), {$urandom, $urandom}, p, 1'($urandom_range(0, 1)),
                           {$urandom, $urandom});
                1: run_irq(p, e, $urandom_range(0, 4), {$urandom, $urandom});
                default: run_irq_exc(p, e, $urandom_range(0, 4), 6'($urandom_range(0, 15)),
                                     {$urandom, $urandom}, {$urandom, $urandom});
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(negedge CLK); quiet(); retire_rand(); #1;
                chk("gap_busy", BUSY, 0); chk("gap_stall", STALL, 0); commit();
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
